memory_arbiter: RTL and testbench
=================================

Name: memory_arbiter

Overview:
- Shares one single-ported RAM between the datapath's instruction fetch port and data port.
- Latches one request per access, drives the RAM, and waits for RAM ready.
- Returns a one-cycle ihit or dhit together with the load data.
- Data requests have priority, with a bounded-starvation guarantee for instruction fetch.
- Sits between datapath_cache_if (datapath side) and the RAM model.

Parameters:
- STARVE_MAX, 4: after this many consecutive data grants issued while iREN is pending, the next grant goes to instruction fetch.
- ADDR_W, 32: address and data width (word_t).

Ports:
- CLK  in  1  clock
- nRST  in  1  asynchronous active-low reset
- iREN  in  1  instruction read request (datapath imemREN)
- iaddr  in  ADDR_W  instruction address
- iload  out  ADDR_W  instruction read data, valid while ihit=1
- ihit  out  1  instruction access complete, one-cycle pulse
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  ADDR_W  data address
- dstore  in  ADDR_W  data write value
- dload  out  ADDR_W  data read data, valid while dhit=1
- dhit  out  1  data access complete, one-cycle pulse
- halt  in  1  once high, no new instruction grants are issued
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  ADDR_W  RAM address
- ramstore  out  ADDR_W  RAM write data
- ramload  in  ADDR_W  RAM read data
- ramready  in  1  RAM access complete this cycle
- busy  out  1  high when state is not IDLE

Behaviour:
- Reset: nRST, asynchronous, active-low; clock CLK.
- Reset values: state=IDLE, ihit=dhit=0, ramREN=ramWEN=0, ramaddr=0, ramstore=0, busy=0, starve_cnt=0, latched address/data/op=0.
- Reset asserted mid-access: immediate return to IDLE, RAM enables drop asynchronously, no hit is issued.
- States:
  - IDLE: arbitrates.
  - IACC: instruction read in flight.
  - DACC: data read or write in flight.
- IDLE arbitration, evaluated every cycle:
  - Data request (dREN|dWEN) and not (starve_cnt==STARVE_MAX and iREN and !halt): go to DACC. Latch daddr, dstore, op. If dWEN and dREN are both high, op=write.
  - Else if iREN and !halt: go to IACC. Latch iaddr.
  - Else: stay in IDLE.
- RAM drive in IACC/DACC: ramaddr, ramstore, ramREN and ramWEN come from the latched registers, combinational on state.
- RAM drive in IDLE: ramREN=ramWEN=0; ramaddr and ramstore hold their last value.
- Completion: in IACC/DACC with ramready=1:
  - Pulse ihit (IACC) or dhit (DACC) for that same cycle.
  - iload or dload = ramload combinationally in that cycle; both loads are 0 otherwise.
  - Next state is IDLE. ihit and dhit are never high together.
- No ramready: stay in IACC/DACC with all RAM signals held stable.
- Minimum latency: request in cycle n (IDLE), access cycle n+1; if ramready is high then, the hit is in n+1. One dead IDLE cycle always follows each access, so back-to-back accesses take 2 cycles each.
- Requester protocol: the requester holds its request and address until the hit. Dropping the request mid-access does not abort the access; it completes and the hit still pulses.
- starve_cnt, width $clog2(STARVE_MAX+1):
  - Increments (saturating at STARVE_MAX) on each IDLE→DACC grant while iREN=1 and halt=0.
  - Clears on any IDLE→IACC grant.
  - Clears in IDLE when iREN=0 or halt=1.
- halt: once high, no IACC grant is issued. An instruction access already in flight completes normally. Data requests continue to be serviced.
- Same-cycle ihit and new request: a request that appears in the cycle of a hit is not seen until the following IDLE cycle.

Test Plan:
- Reset mid-DACC: reset with a write in flight → ramWEN falls within the same cycle, state=IDLE, dhit never pulses; after release with no requests, all outputs are 0.
- Single instruction fetch: iREN=1, iaddr=0x40, ramready held high, ramload=0x8C220004 → ramREN=1 and ramaddr=0x40 in cycle 1, ihit=1 with iload=0x8C220004 in cycle 1, busy=0 in cycle 2.
- Simultaneous requests: iREN=1 with iaddr=0x44, dREN=1 with daddr=0x100, RAM latency 3 cycles → data access first with dhit at cycle 3; instruction access starts at cycle 5 and ihit is at cycle 7.
- Write priority and stability: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, ramready delayed 5 cycles → ramWEN, ramaddr and ramstore stay stable for all 5 cycles; dhit pulses exactly once.
- Starvation: STARVE_MAX=4, iREN held, dREN re-asserted after every dhit → exactly 4 data grants, then 1 instruction grant, then starve_cnt=0 and data resumes.
- Halt: halt=1 while iREN=1 and dREN=1 → only data accesses are granted; ihit stays 0 indefinitely; an instruction access already in flight when halt rises still yields its ihit.

Source files
------------

// File: rtl/memory_arbiter_if.sv
// Bus bundle between the arbiter, the datapath fetch/data ports and the RAM model.
// The master modport is the arbiter's view; slave is the datapath/RAM side.
interface memory_arbiter_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              iREN;
    logic [ADDR_W-1:0] iaddr;
    logic [ADDR_W-1:0] iload;
    logic              ihit;
    logic              dREN;
    logic              dWEN;
    logic [ADDR_W-1:0] daddr;
    logic [ADDR_W-1:0] dstore;
    logic [ADDR_W-1:0] dload;
    logic              dhit;
    logic              halt;
    logic              ramREN;
    logic              ramWEN;
    logic [ADDR_W-1:0] ramaddr;
    logic [ADDR_W-1:0] ramstore;
    logic [ADDR_W-1:0] ramload;
    logic              ramready;
    logic              busy;

    modport master (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramready,
        output iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, busy
    );

    modport slave (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, halt, ramload, ramready,
        input  iload, ihit, dload, dhit, ramREN, ramWEN, ramaddr, ramstore, busy
    );
endinterface

// File: rtl/memory_arbiter.sv
// Shares one single-ported RAM between instruction fetch and data access.
// Data wins arbitration, but fetch is granted after STARVE_MAX data grants in a row.
module memory_arbiter #(
    parameter int unsigned STARVE_MAX = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    memory_arbiter_if.master  bus
);
    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {StIdle, StIacc, StDacc} state_e;

    state_e            state_q;
    logic [CntW-1:0]   starve_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] data_q;
    logic              wr_q;

    logic data_req;
    logic i_req;
    logic starved;

    assign data_req = bus.dREN | bus.dWEN;
    assign i_req    = bus.iREN & ~bus.halt;
    assign starved  = i_req && (starve_cnt_q == CntW'(STARVE_MAX));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q      <= StIdle;
            starve_cnt_q <= '0;
            addr_q       <= '0;
            data_q       <= '0;
            wr_q         <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!i_req) starve_cnt_q <= '0;
                    if (data_req && !starved) begin
                        state_q <= StDacc;
                        addr_q  <= bus.daddr;
                        data_q  <= bus.dstore;
                        // A simultaneous read and write resolves to a write.
                        wr_q    <= bus.dWEN;
                        if (i_req && (starve_cnt_q != CntW'(STARVE_MAX))) begin
                            starve_cnt_q <= starve_cnt_q + CntW'(1);
                        end
                    end else if (i_req) begin
                        state_q      <= StIacc;
                        addr_q       <= bus.iaddr;
                        wr_q         <= 1'b0;
                        starve_cnt_q <= '0;
                    end
                end
                StIacc, StDacc: begin
                    if (bus.ramready) state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // RAM drive is decoded from state so reset drops the enables asynchronously.
    assign bus.ramREN   = (state_q == StIacc) || ((state_q == StDacc) && !wr_q);
    assign bus.ramWEN   = (state_q == StDacc) && wr_q;
    assign bus.ramaddr  = addr_q;
    assign bus.ramstore = data_q;

    assign bus.ihit  = (state_q == StIacc) && bus.ramready;
    assign bus.dhit  = (state_q == StDacc) && bus.ramready;
    assign bus.iload = bus.ihit ? bus.ramload : '0;
    assign bus.dload = bus.dhit ? bus.ramload : '0;
    assign bus.busy  = (state_q != StIdle);
endmodule

// File: tb/tb_memory_arbiter.sv
// Directed bench for memory_arbiter with a variable-latency RAM model.
module tb_memory_arbiter;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    memory_arbiter_if #(.ADDR_W(32)) bus ();

    memory_arbiter #(.STARVE_MAX(4), .ADDR_W(32)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int          passed = 0;
    int          total  = 0;
    int          lat    = 1;
    int          acc_cnt;
    logic [31:0] ram_data = '0;

    // RAM model: ready on the lat-th cycle of an access.
    assign bus.ramload  = ram_data;
    assign bus.ramready = (bus.ramREN | bus.ramWEN) && (acc_cnt == lat - 1);

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) acc_cnt <= 0;
        else if ((bus.ramREN | bus.ramWEN) && !bus.ramready) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
    end

    int          ihit_cnt  = 0;
    int          dhit_cnt  = 0;
    logic        busy_prev = 1'b0;
    logic [31:0] grants[$];

    always @(negedge CLK) begin
        if (bus.ihit) ihit_cnt <= ihit_cnt + 1;
        if (bus.dhit) dhit_cnt <= dhit_cnt + 1;
        if (bus.busy && !busy_prev) grants.push_back(bus.ramaddr);
        busy_prev <= bus.busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        bus.iREN   = 1'b0;
        bus.iaddr  = '0;
        bus.dREN   = 1'b0;
        bus.dWEN   = 1'b0;
        bus.daddr  = '0;
        bus.dstore = '0;
        bus.halt   = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        total++;
        if ({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.busy} !== 5'b0)
            $display("FAIL reset_ctrl: got %b expected %b",
                     {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.busy}, 5'b0);
        else passed++;
        total++;
        if ({bus.ramaddr, bus.ramstore} !== 64'h0)
            $display("FAIL reset_ram: got %h expected %h", {bus.ramaddr, bus.ramstore}, 64'h0);
        else passed++;
        total++;
        if ({bus.iload, bus.dload} !== 64'h0)
            $display("FAIL reset_loads: got %h expected %h", {bus.iload, bus.dload}, 64'h0);
        else passed++;
        nRST = 1'b1;
        cyc();
        total++;
        if (bus.busy !== 1'b0) $display("FAIL reset_idle: got %b expected 0", bus.busy);
        else passed++;
    endtask

    task automatic test_single_fetch();
        lat        = 1;
        ram_data   = 32'h8C22_0004;
        bus.iREN   = 1'b1;
        bus.iaddr  = 32'h40;
        cyc();
        total++;
        if ({bus.ramREN, bus.ramWEN} !== 2'b10)
            $display("FAIL fetch_ren: got %b expected %b", {bus.ramREN, bus.ramWEN}, 2'b10);
        else passed++;
        total++;
        if (bus.ramaddr !== 32'h40)
            $display("FAIL fetch_addr: got %h expected %h", bus.ramaddr, 32'h40);
        else passed++;
        total++;
        if ({bus.ihit, bus.dhit} !== 2'b10)
            $display("FAIL fetch_hit: got %b expected %b", {bus.ihit, bus.dhit}, 2'b10);
        else passed++;
        total++;
        if (bus.iload !== 32'h8C22_0004)
            $display("FAIL fetch_iload: got %h expected %h", bus.iload, 32'h8C22_0004);
        else passed++;
        bus.iREN = 1'b0;
        cyc();
        total++;
        if ({bus.busy, bus.ihit, bus.ramREN} !== 3'b000)
            $display("FAIL fetch_done: got %b expected %b",
                     {bus.busy, bus.ihit, bus.ramREN}, 3'b000);
        else passed++;
        total++;
        if (bus.iload !== 32'h0) $display("FAIL fetch_iload_zero: got %h expected 0", bus.iload);
        else passed++;
    endtask

    task automatic test_simultaneous();
        lat       = 3;
        ram_data  = 32'h1111_2222;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h44;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h100;
        for (int c = 1; c <= 8; c++) begin
            logic [2:0]  exp_flags;
            logic [31:0] exp_addr;
            cyc();
            exp_flags = {(c inside {1, 2, 3, 5, 6, 7}), (c == 3), (c == 7)};
            exp_addr  = (c <= 4) ? 32'h100 : 32'h44;
            total++;
            if ({bus.busy, bus.dhit, bus.ihit} !== exp_flags)
                $display("FAIL simul_flags c%0d: got %b expected %b",
                         c, {bus.busy, bus.dhit, bus.ihit}, exp_flags);
            else passed++;
            total++;
            if (bus.ramaddr !== exp_addr)
                $display("FAIL simul_addr c%0d: got %h expected %h", c, bus.ramaddr, exp_addr);
            else passed++;
            if (c == 3) begin
                total++;
                if (bus.dload !== 32'h1111_2222)
                    $display("FAIL simul_dload: got %h expected %h", bus.dload, 32'h1111_2222);
                else passed++;
                bus.dREN = 1'b0;
            end
            if (c == 7) begin
                total++;
                if ({bus.iload, bus.dload} !== {32'h1111_2222, 32'h0})
                    $display("FAIL simul_loads: got %h expected %h",
                             {bus.iload, bus.dload}, {32'h1111_2222, 32'h0});
                else passed++;
                bus.iREN = 1'b0;
            end
        end
    endtask

    task automatic test_write_stable();
        int d0;
        d0         = dhit_cnt;
        lat        = 5;
        bus.dWEN   = 1'b1;
        bus.dREN   = 1'b1;
        bus.daddr  = 32'h200;
        bus.dstore = 32'hDEAD_BEEF;
        for (int c = 1; c <= 5; c++) begin
            cyc();
            total++;
            if ({bus.ramWEN, bus.ramREN, bus.dhit} !== {2'b10, (c == 5)})
                $display("FAIL write_ctrl c%0d: got %b expected %b",
                         c, {bus.ramWEN, bus.ramREN, bus.dhit}, {2'b10, (c == 5)});
            else passed++;
            total++;
            if ({bus.ramaddr, bus.ramstore} !== {32'h200, 32'hDEAD_BEEF})
                $display("FAIL write_bus c%0d: got %h expected %h",
                         c, {bus.ramaddr, bus.ramstore}, {32'h200, 32'hDEAD_BEEF});
            else passed++;
        end
        bus.dWEN = 1'b0;
        bus.dREN = 1'b0;
        cyc();
        total++;
        if ({bus.busy, bus.ramWEN, bus.dhit} !== 3'b000)
            $display("FAIL write_done: got %b expected %b",
                     {bus.busy, bus.ramWEN, bus.dhit}, 3'b000);
        else passed++;
        total++;
        if (bus.ramaddr !== 32'h200)
            $display("FAIL write_addr_hold: got %h expected %h", bus.ramaddr, 32'h200);
        else passed++;
        total++;
        if (dhit_cnt - d0 !== 1) $display("FAIL write_dhit_once: got %0d expected 1", dhit_cnt - d0);
        else passed++;
    endtask

    task automatic test_reset_mid();
        int d0;
        d0         = dhit_cnt;
        lat        = 100;
        bus.dWEN   = 1'b1;
        bus.daddr  = 32'h208;
        bus.dstore = 32'h1234_5678;
        cyc();
        cyc();
        total++;
        if (bus.ramWEN !== 1'b1) $display("FAIL rstmid_inflight: got %b expected 1", bus.ramWEN);
        else passed++;
        #2;
        nRST = 1'b0;
        #1;
        total++;
        if ({bus.ramWEN, bus.busy, bus.dhit} !== 3'b000)
            $display("FAIL rstmid_drop: got %b expected %b",
                     {bus.ramWEN, bus.busy, bus.dhit}, 3'b000);
        else passed++;
        idle_inputs();
        @(posedge CLK);
        #1;
        nRST = 1'b1;
        lat  = 1;
        cyc();
        total++;
        if ({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.busy, bus.ramaddr, bus.ramstore,
             bus.iload, bus.dload} !== '0)
            $display("FAIL rstmid_outputs: got %b %h %h expected all zero",
                     {bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.busy},
                     bus.ramaddr, bus.ramstore);
        else passed++;
        total++;
        if (dhit_cnt !== d0) $display("FAIL rstmid_no_dhit: got %0d expected %0d", dhit_cnt, d0);
        else passed++;
    endtask

    task automatic test_starvation();
        int base, ih0, dh0;
        logic [31:0] exp;
        base      = grants.size();
        ih0       = ihit_cnt;
        dh0       = dhit_cnt;
        lat       = 1;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h80;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h300;
        for (int i = 0; i < 100 && grants.size() < base + 10; i++) cyc();
        idle_inputs();
        total++;
        if (grants.size() < base + 10)
            $display("FAIL starve_timeout: got %0d grants expected 10", grants.size() - base);
        else passed++;
        for (int k = 0; k < 10; k++) begin
            exp = (k == 4 || k == 9) ? 32'h80 : 32'h300;
            if (grants.size() > base + k) begin
                total++;
                if (grants[base+k] !== exp)
                    $display("FAIL starve_grant%0d: got %h expected %h", k, grants[base+k], exp);
                else passed++;
            end
        end
        cyc();
        total++;
        if ({ihit_cnt - ih0, dhit_cnt - dh0} !== {32'd2, 32'd8})
            $display("FAIL starve_hits: got i=%0d d=%0d expected i=2 d=8",
                     ihit_cnt - ih0, dhit_cnt - dh0);
        else passed++;
    endtask

    task automatic test_halt();
        int base, ih0, dh0, bad;
        base      = grants.size();
        ih0       = ihit_cnt;
        dh0       = dhit_cnt;
        bad       = 0;
        lat       = 3;
        bus.iREN  = 1'b1;
        bus.iaddr = 32'h84;
        cyc();
        total++;
        if ({bus.ramREN, bus.ramaddr} !== {1'b1, 32'h84})
            $display("FAIL halt_fetch_start: got %b %h expected 1 %h",
                     bus.ramREN, bus.ramaddr, 32'h84);
        else passed++;
        bus.halt  = 1'b1;
        bus.dREN  = 1'b1;
        bus.daddr = 32'h304;
        for (int i = 0; i < 30; i++) cyc();
        idle_inputs();
        for (int i = 0; i < 10 && bus.busy; i++) cyc();
        cyc();
        total++;
        if (ihit_cnt - ih0 !== 1)
            $display("FAIL halt_inflight_ihit: got %0d expected 1", ihit_cnt - ih0);
        else passed++;
        total++;
        if (grants.size() - base !== 8)
            $display("FAIL halt_grant_count: got %0d expected 8", grants.size() - base);
        else passed++;
        for (int k = base + 1; k < grants.size(); k++) if (grants[k] !== 32'h304) bad++;
        total++;
        if (bad !== 0) $display("FAIL halt_only_data: got %0d fetch grants expected 0", bad);
        else passed++;
        total++;
        if (dhit_cnt - dh0 !== 7) $display("FAIL halt_dhits: got %0d expected 7", dhit_cnt - dh0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_write_stable();
        test_reset_mid();
        test_starvation();
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
